// File: rtl/udp_stream_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : udp_stream_arbiter_if
// Brief    : N-source AXI-Stream merge bus feeding the UDP master stream input.
// Revision : 1.0
// ============================================================================
interface udp_stream_arbiter_if #(
    parameter int N_SRC    = 4,
    parameter int ID_WIDTH = 2
);
    logic [N_SRC*32-1:0] s_tdata;
    logic [N_SRC*4-1:0]  s_tkeep;
    logic [N_SRC-1:0]    s_tlast;
    logic [N_SRC-1:0]    s_tvalid;
    logic [N_SRC-1:0]    s_tready;
    logic [N_SRC-1:0]    src_enable;
    logic [ID_WIDTH-1:0] m_tid;
    logic [31:0]         m_tdata;
    logic [3:0]          m_tkeep;
    logic                m_tlast;
    logic                m_tvalid;
    logic                m_tready;
    logic                busy;
    logic [31:0]         pkt_cnt;

    // Arbiter side
    modport slave (
        input  s_tdata, s_tkeep, s_tlast, s_tvalid, src_enable, m_tready,
        output s_tready, m_tid, m_tdata, m_tkeep, m_tlast, m_tvalid, busy, pkt_cnt
    );

    // Environment side: sources plus downstream consumer
    modport master (
        output s_tdata, s_tkeep, s_tlast, s_tvalid, src_enable, m_tready,
        input  s_tready, m_tid, m_tdata, m_tkeep, m_tlast, m_tvalid, busy, pkt_cnt
    );
endinterface
`default_nettype wire

// File: rtl/udp_stream_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : udp_stream_arbiter
// Brief    : Packet-level round-robin merge of N_SRC streams, skid-buffered out.
// Revision : 1.0
// ============================================================================
module udp_stream_arbiter #(
    parameter int N_SRC    = 4,
    parameter int ID_WIDTH = 2
) (
    input  logic                clk,
    input  logic                reset,
    udp_stream_arbiter_if.slave bus
);
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } state_t;

    localparam logic [ID_WIDTH-1:0] c_LAST_INIT = ID_WIDTH'(N_SRC - 1);

    state_t              r_state, w_state_nxt;
    logic [ID_WIDTH-1:0] r_grant, w_grant_nxt;
    logic [ID_WIDTH-1:0] r_last_grant, w_last_grant_nxt;
    logic [ID_WIDTH-1:0] w_winner;
    logic                w_found;
    logic [N_SRC-1:0]    w_req;
    logic [N_SRC-1:0]    r_s_tready, w_s_tready_nxt;
    logic                w_accept, w_main_open, w_sk_valid_nxt;
    logic [31:0]         w_in_data;
    logic [3:0]          w_in_keep;
    logic                w_in_last;

    logic                r_m_valid, r_m_last;
    logic [ID_WIDTH-1:0] r_m_tid;
    logic [31:0]         r_m_data;
    logic [3:0]          r_m_keep;
    logic                r_sk_valid, r_sk_last;
    logic [ID_WIDTH-1:0] r_sk_tid;
    logic [31:0]         r_sk_data;
    logic [3:0]          r_sk_keep;
    logic [31:0]         r_pkt_cnt;

    assign w_req       = bus.s_tvalid & bus.src_enable;
    // Ready is only ever set on the granted bit, so any handshake is the grant's
    assign w_accept    = |(bus.s_tvalid & r_s_tready);
    assign w_main_open = ~r_m_valid | bus.m_tready;
    assign w_sk_valid_nxt = r_sk_valid ? ~w_main_open : (w_accept & ~w_main_open);

    always_comb begin : p_src_mux
        w_in_data = '0;
        w_in_keep = '0;
        w_in_last = 1'b0;
        for (int i = 0; i < N_SRC; i++) begin
            if (r_grant == ID_WIDTH'(i)) begin
                w_in_data = bus.s_tdata[i*32 +: 32];
                w_in_keep = bus.s_tkeep[i*4 +: 4];
                w_in_last = bus.s_tlast[i];
            end
        end
    end

    // First requester after the previous winner, wrapping modulo N_SRC
    always_comb begin : p_rr_search
        logic [ID_WIDTH-1:0] v_idx;
        v_idx    = '0;
        w_found  = 1'b0;
        w_winner = '0;
        for (int k = 1; k <= N_SRC; k++) begin
            v_idx = ID_WIDTH'((int'(r_last_grant) + k) % N_SRC);
            if (!w_found && w_req[v_idx]) begin
                w_found  = 1'b1;
                w_winner = v_idx;
            end
        end
    end

    always_comb begin : p_fsm_next
        w_state_nxt      = r_state;
        w_grant_nxt      = r_grant;
        w_last_grant_nxt = r_last_grant;
        w_s_tready_nxt   = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_state_nxt = ST_XFER;
                    w_grant_nxt = w_winner;
                end
            end
            ST_XFER: begin
                if (w_accept && w_in_last) begin
                    w_state_nxt      = ST_IDLE;
                    w_last_grant_nxt = r_grant;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        if (w_state_nxt == ST_XFER && !w_sk_valid_nxt) begin
            for (int i = 0; i < N_SRC; i++) begin
                w_s_tready_nxt[i] = (w_grant_nxt == ID_WIDTH'(i));
            end
        end
    end

    always_ff @(posedge clk) begin : p_fsm_reg
        if (reset) begin
            r_state      <= ST_IDLE;
            r_grant      <= '0;
            r_last_grant <= c_LAST_INIT;
            r_s_tready   <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_grant      <= w_grant_nxt;
            r_last_grant <= w_last_grant_nxt;
            r_s_tready   <= w_s_tready_nxt;
        end
    end

    // Main register refills from the skid first so beat order is preserved
    always_ff @(posedge clk) begin : p_out_stage
        if (reset) begin
            r_m_valid  <= 1'b0;
            r_m_tid    <= '0;
            r_m_data   <= '0;
            r_m_keep   <= '0;
            r_m_last   <= 1'b0;
            r_sk_valid <= 1'b0;
            r_sk_tid   <= '0;
            r_sk_data  <= '0;
            r_sk_keep  <= '0;
            r_sk_last  <= 1'b0;
        end else if (w_main_open) begin
            if (r_sk_valid) begin
                r_m_valid  <= 1'b1;
                r_m_tid    <= r_sk_tid;
                r_m_data   <= r_sk_data;
                r_m_keep   <= r_sk_keep;
                r_m_last   <= r_sk_last;
                r_sk_valid <= 1'b0;
            end else if (w_accept) begin
                r_m_valid <= 1'b1;
                r_m_tid   <= r_grant;
                r_m_data  <= w_in_data;
                r_m_keep  <= w_in_keep;
                r_m_last  <= w_in_last;
            end else begin
                r_m_valid <= 1'b0;
            end
        end else if (w_accept) begin
            r_sk_valid <= 1'b1;
            r_sk_tid   <= r_grant;
            r_sk_data  <= w_in_data;
            r_sk_keep  <= w_in_keep;
            r_sk_last  <= w_in_last;
        end
    end

    always_ff @(posedge clk) begin : p_pkt_cnt
        if (reset) begin
            r_pkt_cnt <= '0;
        end else if (r_m_valid && bus.m_tready && r_m_last) begin
            r_pkt_cnt <= r_pkt_cnt + 32'd1;
        end
    end

    assign bus.s_tready = r_s_tready;
    assign bus.m_tvalid = r_m_valid;
    assign bus.m_tid    = r_m_tid;
    assign bus.m_tdata  = r_m_data;
    assign bus.m_tkeep  = r_m_keep;
    assign bus.m_tlast  = r_m_last;
    assign bus.busy     = (r_state == ST_XFER);
    assign bus.pkt_cnt  = r_pkt_cnt;

endmodule
`default_nettype wire

// File: tb/tb_udp_stream_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_udp_stream_arbiter
// Brief    : Randomized scenario bench with packet-level round-robin model.
// Revision : 1.0
// ============================================================================
module tb_udp_stream_arbiter;
    localparam int N_SRC    = 4;
    localparam int ID_WIDTH = 2;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } beat_t;

    typedef struct packed {
        logic [ID_WIDTH-1:0] tid;
        logic [31:0]         data;
        logic [3:0]          keep;
        logic                last;
    } obeat_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    udp_stream_arbiter_if #(.N_SRC(N_SRC), .ID_WIDTH(ID_WIDTH)) bus ();

    udp_stream_arbiter #(.N_SRC(N_SRC), .ID_WIDTH(ID_WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    beat_t            src_q[N_SRC][$];
    bit               at_first[N_SRC];
    int               acc_cnt[N_SRC];
    obeat_t           exp_q[$];
    int               exp_pkts;
    int               acc_cyc[$];
    int               out_cyc[$];
    int               busy_cycles;
    int               cyc = 0;
    int               errors = 0;
    int               checks = 0;
    int               dis_src, dis_at;
    logic [N_SRC-1:0] en_after;
    int               stop_src, stop_at;
    bit               vgap;

    task automatic clear_model();
        for (int i = 0; i < N_SRC; i++) begin
            src_q[i].delete();
            at_first[i] = 1'b1;
            acc_cnt[i]  = 0;
        end
        exp_q.delete();
        acc_cyc.delete();
        out_cyc.delete();
        busy_cycles = 0;
        exp_pkts    = 0;
        dis_src     = -1;
        dis_at      = 0;
        en_after    = '1;
        stop_src    = -1;
        stop_at     = 0;
        vgap        = 1'b0;
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        bus.s_tvalid   = '0;
        bus.s_tdata    = '0;
        bus.s_tkeep    = '0;
        bus.s_tlast    = '0;
        bus.m_tready   = 1'b0;
        bus.src_enable = '1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        clear_model();
    endtask

    task automatic add_pkt(input int s, input int len, input logic [31:0] base, input bit rkeep);
        for (int j = 0; j < len; j++) begin
            beat_t b;
            b.data = base + 32'(j);
            b.keep = rkeep ? 4'($urandom) : 4'hF;
            b.last = (j == len - 1);
            src_q[s].push_back(b);
        end
    endtask

    task automatic push_exp_from(input int s, input int nbeats);
        for (int j = 0; j < nbeats; j++) begin
            exp_q.push_back({ID_WIDTH'(s), src_q[s][j].data, src_q[s][j].keep, src_q[s][j].last});
        end
    endtask

    // Whole packets leave in round-robin order among sources that still hold packets
    task automatic model_order(input logic [N_SRC-1:0] en);
        int pos[N_SRC];
        int last;
        int pick;
        bit found;
        last = N_SRC - 1;
        pick = 0;
        for (int i = 0; i < N_SRC; i++) pos[i] = 0;
        do begin
            found = 1'b0;
            for (int k = 1; k <= N_SRC; k++) begin
                int s;
                s = (last + k) % N_SRC;
                if (!found && en[s] && pos[s] < src_q[s].size()) begin
                    found = 1'b1;
                    pick  = s;
                end
            end
            if (found) begin
                bit done;
                done = 1'b0;
                while (!done) begin
                    beat_t b;
                    b = src_q[pick][pos[pick]];
                    exp_q.push_back({ID_WIDTH'(pick), b.data, b.keep, b.last});
                    pos[pick]++;
                    done = b.last;
                end
                exp_pkts++;
                last = pick;
            end
        end while (found);
    endtask

    task automatic run_traffic(input int rdy_mode, input int max_cyc, input int tail);
        logic [N_SRC-1:0]    v, l;
        logic [N_SRC*32-1:0] d;
        logic [N_SRC*4-1:0]  k;
        obeat_t              cur, held;
        bit                  hold, stopped;
        int                  n, t;
        hold = 1'b0; stopped = 1'b0; n = 0; t = 0; held = '0;
        v = '0; l = '0; d = '0; k = '0;
        while (n < max_cyc && (exp_q.size() > 0 || t < tail)) begin
            @(negedge clk);
            n++;
            cyc++;
            if (exp_q.size() == 0) t++;
            cur = {bus.m_tid, bus.m_tdata, bus.m_tkeep, bus.m_tlast};
            if (hold) begin
                checks++;
                if (cur !== held || bus.m_tvalid !== 1'b1) begin
                    errors++;
                    $display("FAIL stall_stable: got v=%b %h required v=1 %h", bus.m_tvalid, cur, held);
                end
            end
            if (stop_src >= 0 && acc_cnt[stop_src] >= stop_at) begin
                stopped = 1'b1;
                break;
            end
            if (dis_src >= 0 && acc_cnt[dis_src] >= dis_at) begin
                bus.src_enable = en_after;
                dis_src = -1;
            end
            for (int i = 0; i < N_SRC; i++) begin
                if (src_q[i].size() > 0) begin
                    v[i]          = at_first[i] || !vgap || ($urandom_range(3) != 0);
                    d[i*32 +: 32] = src_q[i][0].data;
                    k[i*4 +: 4]   = src_q[i][0].keep;
                    l[i]          = src_q[i][0].last;
                end else begin
                    v[i]          = 1'b0;
                    d[i*32 +: 32] = $urandom;
                    k[i*4 +: 4]   = 4'($urandom);
                    l[i]          = 1'($urandom);
                end
            end
            bus.s_tvalid = v;
            bus.s_tdata  = d;
            bus.s_tkeep  = k;
            bus.s_tlast  = l;
            case (rdy_mode)
                0:       bus.m_tready = 1'b1;
                1:       bus.m_tready = (n % 4 == 1) || (n % 4 == 0);
                default: bus.m_tready = 1'($urandom_range(1));
            endcase
            checks++;
            if ($countones(bus.s_tready) > 1 || (bus.busy !== 1'b1 && bus.s_tready !== '0)) begin
                errors++;
                $display("FAIL tready_onehot: got s_tready=%b busy=%b required <=1 bit and only while busy",
                         bus.s_tready, bus.busy);
            end
            for (int i = 0; i < N_SRC; i++) begin
                if (v[i] && bus.s_tready[i] === 1'b1) begin
                    at_first[i] = src_q[i][0].last;
                    src_q[i].pop_front();
                    acc_cnt[i]++;
                    acc_cyc.push_back(cyc);
                end
            end
            if (bus.m_tvalid === 1'b1 && bus.m_tready) begin
                out_cyc.push_back(cyc);
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL out_beat: got unexpected beat %h required none", cur);
                end else begin
                    if (cur !== exp_q[0]) begin
                        errors++;
                        $display("FAIL out_beat: got %h required %h", cur, exp_q[0]);
                    end
                    void'(exp_q.pop_front());
                end
            end
            if (bus.busy === 1'b1) busy_cycles++;
            hold = (bus.m_tvalid === 1'b1) && !bus.m_tready;
            held = cur;
        end
        if (!stopped) begin
            checks++;
            if (exp_q.size() != 0) begin
                errors++;
                $display("FAIL timeout: got %0d beats outstanding required 0", exp_q.size());
            end
        end
    endtask

    task automatic check_pkt_cnt(input logic [31:0] want);
        checks++;
        if (bus.pkt_cnt !== want) begin
            errors++;
            $display("FAIL pkt_cnt: got %0d required %0d", bus.pkt_cnt, want);
        end
    endtask

    task automatic check_gaps(input int beats_per_pkt);
        for (int i = 1; i < acc_cyc.size(); i++) begin
            int want;
            want = (i % beats_per_pkt == 0) ? 2 : 1;
            checks++;
            if (acc_cyc[i] - acc_cyc[i-1] != want) begin
                errors++;
                $display("FAIL accept_spacing: got %0d required %0d at beat %0d",
                         acc_cyc[i] - acc_cyc[i-1], want, i);
            end
        end
    endtask

    task automatic test_reset();
        reset          = 1'b1;
        bus.s_tvalid   = '1;
        bus.s_tdata    = {N_SRC{32'hDEADBEEF}};
        bus.s_tkeep    = '1;
        bus.s_tlast    = '0;
        bus.src_enable = '1;
        bus.m_tready   = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({bus.m_tvalid, bus.m_tid, bus.m_tdata, bus.m_tkeep, bus.m_tlast, bus.s_tready, bus.busy} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b id=%h d=%h k=%h l=%b rdy=%b busy=%b required all 0",
                     bus.m_tvalid, bus.m_tid, bus.m_tdata, bus.m_tkeep, bus.m_tlast, bus.s_tready, bus.busy);
        end
        check_pkt_cnt(32'd0);
        bus.s_tvalid = '0;
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.s_tready !== '0) begin
            errors++;
            $display("FAIL idle_no_req: got busy=%b rdy=%b required 0", bus.busy, bus.s_tready);
        end
    endtask

    task automatic test_single_source();
        do_reset();
        add_pkt(0, 4, 32'h100, 1'b0);
        model_order('1);
        run_traffic(0, 60, 4);
        check_gaps(4);
        checks++;
        if (busy_cycles != 4) begin
            errors++;
            $display("FAIL busy_cycles: got %0d required 4", busy_cycles);
        end
        for (int i = 0; i < 4 && i < out_cyc.size() && i < acc_cyc.size(); i++) begin
            checks++;
            if (out_cyc[i] != acc_cyc[i] + 1) begin
                errors++;
                $display("FAIL latency: got %0d required 1", out_cyc[i] - acc_cyc[i]);
            end
        end
        check_pkt_cnt(32'd1);
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int s = 0; s < N_SRC; s++) add_pkt(s, 2, 32'h200 + 32'(s * 16), 1'b1);
        model_order('1);
        run_traffic(0, 100, 4);
        check_gaps(2);
        check_pkt_cnt(32'd4);
    endtask

    task automatic test_backpressure();
        do_reset();
        add_pkt(2, 8, 32'h300, 1'b1);
        model_order('1);
        run_traffic(1, 200, 4);
        checks++;
        if (out_cyc.size() != 8) begin
            errors++;
            $display("FAIL bp_beats: got %0d required 8", out_cyc.size());
        end
        check_pkt_cnt(32'd1);
    endtask

    task automatic test_enable();
        do_reset();
        bus.src_enable = 4'b0010;
        add_pkt(1, 5, 32'h400, 1'b0);
        add_pkt(1, 2, 32'h480, 1'b0);
        add_pkt(0, 3, 32'h500, 1'b1);
        push_exp_from(1, 5);
        push_exp_from(0, 3);
        dis_src  = 1;
        dis_at   = 1;
        en_after = 4'b0001;
        run_traffic(2, 200, 12);
        checks++;
        if (acc_cnt[1] != 5 || acc_cnt[0] != 3) begin
            errors++;
            $display("FAIL enable_grants: got src1=%0d src0=%0d required 5 and 3", acc_cnt[1], acc_cnt[0]);
        end
        check_pkt_cnt(32'd2);
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        add_pkt(3, 6, 32'h600, 1'b0);
        model_order('1);
        stop_src = 3;
        stop_at  = 2;
        run_traffic(0, 60, 0);
        checks++;
        if (acc_cnt[3] != 2) begin
            errors++;
            $display("FAIL mid_reset_setup: got %0d beats in required 2", acc_cnt[3]);
        end
        bus.s_tdata[3*32 +: 32] = src_q[3][0].data;
        bus.s_tlast[3]          = src_q[3][0].last;
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.m_tvalid, bus.m_tid, bus.m_tdata, bus.m_tkeep, bus.m_tlast, bus.s_tready, bus.busy} !== '0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got v=%b id=%h d=%h l=%b rdy=%b busy=%b required all 0",
                     bus.m_tvalid, bus.m_tid, bus.m_tdata, bus.m_tlast, bus.s_tready, bus.busy);
        end
        check_pkt_cnt(32'd0);
        bus.s_tvalid = '0;
        reset = 1'b0;
        clear_model();
        add_pkt(0, 2, 32'h700, 1'b0);
        add_pkt(3, 2, 32'h780, 1'b0);
        model_order('1);
        run_traffic(0, 60, 4);
        check_pkt_cnt(32'd2);
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int p = 0; p < 3; p++) add_pkt(2, 1, 32'h800 + 32'(p), 1'b0);
        model_order('1);
        run_traffic(0, 60, 4);
        check_gaps(1);
        check_pkt_cnt(32'd3);
    endtask

    task automatic test_random();
        int want;
        do_reset();
        for (int s = 0; s < N_SRC; s++) begin
            int np;
            np = $urandom_range(3);
            for (int p = 0; p < np; p++) add_pkt(s, $urandom_range(5, 1), $urandom, 1'b1);
        end
        vgap = 1'b1;
        model_order('1);
        want = exp_pkts;
        run_traffic(2, 2000, 6);
        check_pkt_cnt(32'(want));
    endtask

    initial begin
        test_reset();
        test_single_source();
        test_round_robin();
        test_backpressure();
        test_enable();
        test_reset_mid_packet();
        test_back_to_back();
        for (int r = 0; r < 4; r++) test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/udp_stream_arbiter.md
Name: udp_stream_arbiter

Overview:
- Packet-level round-robin arbiter that merges N_SRC 32-bit AXI-Stream sources onto the single stream input of the UDP master.
- Once a source is granted, it keeps the grant for a whole packet, up to and including its tlast beat.
- The output carries the winning source index on m_tid so downstream logic can select per-source UDP header context.
- The output is fully registered through a skid buffer, so timing is closed at the UDP master boundary.

Parameters:
- N_SRC, 4, number of upstream stream sources (2..8).
- ID_WIDTH, 2, width of m_tid; must equal clog2(N_SRC).

Ports:
- clk  in  1  single clock for the whole block.
- reset  in  1  synchronous, active-high reset.
- s_tdata  in  N_SRC*32  source data; source i occupies bits [32i+31:32i].
- s_tkeep  in  N_SRC*4  source byte enables; source i occupies bits [4i+3:4i].
- s_tlast  in  N_SRC  per-source end of packet.
- s_tvalid  in  N_SRC  per-source valid.
- s_tready  out  N_SRC  per-source ready; only the granted bit may be 1.
- src_enable  in  N_SRC  per-source arbitration enable; takes effect at packet boundaries only.
- m_tid  out  ID_WIDTH  index of the source owning the current beat.
- m_tdata  out  32  output data.
- m_tkeep  out  4  output byte enables.
- m_tlast  out  1  output end of packet.
- m_tvalid  out  1  output valid.
- m_tready  in  1  output ready.
- busy  out  1  1 while a packet is granted (FSM in XFER).
- pkt_cnt  out  32  count of packets forwarded; increments on each output beat with m_tlast accepted.

Behaviour:
- Reset values:
  - All outputs 0: s_tready=0, m_tvalid=0, m_tid/m_tdata/m_tkeep/m_tlast=0, busy=0, pkt_cnt=0.
  - FSM goes to IDLE.
  - Round-robin pointer last_grant = N_SRC-1, so source 0 has priority first.
  - Skid buffer is emptied.
- Reset mid-packet: the packet is abandoned, with no tlast emitted. The source must restart its packet after reset.
- FSM IDLE:
  - Computes req = s_tvalid & src_enable.
  - If req != 0, the winner is the first set bit searching from last_grant+1 upward, modulo N_SRC. The winner is registered into grant and the FSM moves to XFER next cycle.
  - s_tready=0 in IDLE.
- FSM XFER:
  - s_tready[grant] = ~skid_full, driven from a register; all other s_tready bits = 0.
  - A beat is accepted when s_tvalid[grant] & s_tready[grant].
  - When the accepted beat has s_tlast=1: last_grant <= grant, FSM goes to IDLE, and s_tready drops the following cycle.
- Arbitration gap: exactly one IDLE cycle between packets. Packet switch overhead is 1 cycle.
- Fairness:
  - A source that has just finished cannot win again while any other enabled source is requesting.
  - A sole requester may win back-to-back, with the 1-cycle gap.
- src_enable:
  - Sampled only in IDLE.
  - Deasserting it mid-packet does not abort the packet; the packet completes normally.
- Non-granted sources: s_tvalid is ignored; their data may change freely.
- Output stage:
  - Main register plus one skid register.
  - An accepted beat appears on m_* on the next cycle (latency 1) when the main register is empty or is being drained.
  - When m_tready=0 while a beat is held, one further in-flight beat is captured in the skid register and s_tready deasserts the next cycle.
  - No beat is lost or duplicated.
  - While m_tvalid=1 and m_tready=0, m_tid/m_tdata/m_tkeep/m_tlast stay stable.
  - With m_tready held at 1, throughput is 1 beat/cycle within a packet.
- m_tid: equals the grant of the source that supplied the beat; constant across all beats of one packet.
- tkeep: passed through unmodified; no checking or realignment.
- pkt_cnt: wraps from 0xFFFFFFFF to 0.
- Zero-length packets do not exist. A single beat with tlast=1 is a valid 1-beat packet.

Test Plan:
- Single source 0 sends 4 beats (data 0x100..0x103, last on 0x103), m_tready=1 -> m_* shows the 4 beats with m_tid=0, m_tlast only on 0x103, busy high 4 cycles, pkt_cnt=1.
- Sources 0..3 each hold a 2-beat packet valid continuously -> output order is src 0,1,2,3; each packet contiguous; 1-cycle gap between packets; pkt_cnt=4.
- Source 2 sends 8 beats while m_tready toggles 1,0,0,1 repeatedly -> all 8 beats appear in order with no loss or duplication; payload stable while m_tvalid & ~m_tready; SVA stable-valid and stable-payload checks pass.
- Source 1 granted, src_enable[1] cleared at beat 2 of 5 -> all 5 beats complete; afterwards source 1 is never granted while src_enable[1]=0, even with s_tvalid[1]=1.
- reset asserted for 1 cycle during beat 3 of a 6-beat packet from source 3 -> next cycle all outputs 0 and pkt_cnt=0; with sources 0 and 3 both requesting after reset, source 0 wins first.
- Only source 2 requests, sending 3 back-to-back 1-beat packets -> m_tid=2 for each, one IDLE cycle between packets, pkt_cnt=3.
